// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect/halt controller: drives PC select, fetch stall, F flush and EX bubble.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pcsrc_ex,
  input  logic             is_load_ex,
  input  logic             regwrite_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs1_f,
  input  logic [4:0]       rs2_f,
  input  logic             use_rs1_f,
  input  logic             use_rs2_f,
  input  logic             halt_req,
  input  logic             resume,
  output logic [1:0]       pc_sel,
  output logic             stall_fetch,
  output logic             flush_f,
  output logic             bubble_ex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  // Cycles spent in STALL after the first hazard cycle handled in RUN.
  localparam logic [3:0] STALL_LOAD = 4'(LOAD_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] stall_left_q, stall_left_d;
  logic       load_use;

  assign load_use = is_load_ex & regwrite_ex & (rd_ex != 5'd0) &
                    ((use_rs1_f & (rs1_f == rd_ex)) | (use_rs2_f & (rs2_f == rd_ex)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      stall_left_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    pc_sel       = 2'b00;
    stall_fetch  = 1'b0;
    flush_f      = 1'b0;
    bubble_ex    = 1'b0;
    halted       = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (pcsrc_ex != 2'b00) begin
          pc_sel  = pcsrc_ex;
          flush_f = 1'b1;
          state_d = S_FLUSH;
        end else if (halt_req) begin
          state_d = S_HALT;
        end else if (load_use) begin
          stall_fetch = 1'b1;
          bubble_ex   = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d      = S_STALL;
            stall_left_d = STALL_LOAD;
          end
        end
      end
      S_FLUSH: begin
        bubble_ex = 1'b1;
        state_d   = S_RUN;
      end
      S_STALL: begin
        stall_fetch  = 1'b1;
        bubble_ex    = 1'b1;
        stall_left_d = (stall_left_q == 4'd0) ? 4'd0 : stall_left_q - 4'd1;
        if (stall_left_q <= 4'd1) begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        stall_fetch = 1'b1;
        bubble_ex   = 1'b1;
        halted      = 1'b1;
        if (resume) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    // Outputs must read as idle the instant reset asserts, not just after the next edge.
    if (!rst_n) begin
      pc_sel      = 2'b00;
      stall_fetch = 1'b0;
      flush_f     = 1'b0;
      bubble_ex   = 1'b0;
      halted      = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_fetch) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_f)     flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipe_ctrl;
  localparam int LSC  = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst_n;
  logic [1:0]    pcsrc_ex;
  logic          is_load_ex, regwrite_ex;
  logic [4:0]    rd_ex, rs1_f, rs2_f;
  logic          use_rs1_f, use_rs2_f, halt_req, resume;
  logic [1:0]    pc_sel;
  logic          stall_fetch, flush_f, bubble_ex, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the pipeline is doing, in plain terms.
  bit m_halt;
  bit m_flush;
  int m_stall_left;
  int m_scnt, m_fcnt;

  pipe_ctrl #(.LOAD_STALL_CYCLES(LSC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pcsrc_ex(pcsrc_ex), .is_load_ex(is_load_ex),
    .regwrite_ex(regwrite_ex), .rd_ex(rd_ex), .rs1_f(rs1_f), .rs2_f(rs2_f),
    .use_rs1_f(use_rs1_f), .use_rs2_f(use_rs2_f), .halt_req(halt_req), .resume(resume),
    .pc_sel(pc_sel), .stall_fetch(stall_fetch), .flush_f(flush_f), .bubble_ex(bubble_ex),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    pcsrc_ex = 2'b00; is_load_ex = 1'b0; regwrite_ex = 1'b0; rd_ex = 5'd0;
    rs1_f = 5'd0; rs2_f = 5'd0; use_rs1_f = 1'b0; use_rs2_f = 1'b0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic model_reset();
    m_halt = 0; m_flush = 0; m_stall_left = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic set_hazard(input logic [4:0] rd);
    is_load_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = rd; rs2_f = 5'd5; use_rs2_f = 1'b1;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model over the edge.
  task automatic cycle();
    int e_pc, e_sc, e_fc;
    bit e_sf, e_ff, e_bub, e_hl, hz;
    @(negedge clk);
    e_pc = 0; e_sf = 0; e_ff = 0; e_bub = 0; e_hl = 0;
    hz = is_load_ex && regwrite_ex && (rd_ex != 0) &&
         ((use_rs1_f && rs1_f == rd_ex) || (use_rs2_f && rs2_f == rd_ex));
    if (m_halt) begin
      e_sf = 1; e_bub = 1; e_hl = 1;
    end else if (m_flush) begin
      e_bub = 1;
    end else if (m_stall_left > 0) begin
      e_sf = 1; e_bub = 1;
    end else if (pcsrc_ex != 0) begin
      e_pc = pcsrc_ex; e_ff = 1;
    end else if (!halt_req && hz) begin
      e_sf = 1; e_bub = 1;
    end
`ifdef PIPE_CTRL_PERF_EN
    e_sc = m_scnt; e_fc = m_fcnt;
`else
    e_sc = 0; e_fc = 0;
`endif
    check("pc_sel", pc_sel, e_pc);
    check("stall_fetch", stall_fetch, e_sf);
    check("flush_f", flush_f, e_ff);
    check("bubble_ex", bubble_ex, e_bub);
    check("halted", halted, e_hl);
    check("stall_cnt", stall_cnt, e_sc);
    check("flush_cnt", flush_cnt, e_fc);
    if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_stall_left > 0) begin
      m_stall_left--;
    end else if (pcsrc_ex != 0) begin
      m_flush = 1;
    end else if (halt_req) begin
      m_halt = 1;
    end else if (hz) begin
      m_stall_left = LSC - 1;
    end
    if (e_sf && m_scnt < CMAX) m_scnt++;
    if (e_ff && m_fcnt < CMAX) m_fcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    bit hr;
    idle();
    rst_n = 1'b0;
    model_reset();
    pcsrc_ex = 2'b11;
    #2;
    check("rst_pc_sel", pc_sel, 0);
    check("rst_flush_f", flush_f, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    idle();
    do_reset();

    // Taken branch redirect, then one FLUSH cycle.
    pcsrc_ex = 2'b11; cycle();
    idle(); cycle(); cycle();

    // Load-use stall of LSC cycles, then rd=0 which is never a hazard.
    set_hazard(5'd5); cycle();
    idle(); repeat (LSC + 1) cycle();
    set_hazard(5'd0); cycle();
    idle(); cycle();

    // Redirect outranks a simultaneous load-use hazard.
    set_hazard(5'd5); pcsrc_ex = 2'b10; cycle();
    idle(); cycle(); cycle();

    // Halt for 11 cycles then resume.
    do_reset();
    halt_req = 1'b1; cycle();
    halt_req = 1'b0; repeat (10) cycle();
    resume = 1'b1; cycle();
    resume = 1'b0; cycle();
`ifdef PIPE_CTRL_PERF_EN
    check("halt_stall_cnt", stall_cnt, 11);
`else
    check("halt_stall_cnt", stall_cnt, 0);
`endif
    // Resume while halt_req is still high: one RUN cycle, then halted again.
    halt_req = 1'b1; cycle(); cycle();
    resume = 1'b1; cycle();
    resume = 1'b0; cycle(); cycle();
    halt_req = 1'b0; resume = 1'b1; cycle();
    resume = 1'b0; cycle();

    // Asynchronous reset in the middle of a STALL.
    set_hazard(5'd5); cycle();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_stall_fetch", stall_fetch, 0);
    check("mid_rst_bubble_ex", bubble_ex, 0);
    check("mid_rst_halted", halted, 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle(); cycle();

    // Twenty redirects to drive flush_cnt into saturation.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pcsrc_ex = 2'($urandom_range(1, 3)); cycle();
      idle(); cycle();
    end
    cycle();

    // Randomized traffic.
    do_reset();
    hr = 0;
    for (int i = 0; i < 400; i++) begin
      pcsrc_ex    = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
      is_load_ex  = 1'($urandom);
      regwrite_ex = 1'($urandom);
      rd_ex       = 5'($urandom_range(0, 3));
      rs1_f       = 5'($urandom_range(0, 3));
      rs2_f       = 5'($urandom_range(0, 3));
      use_rs1_f   = 1'($urandom);
      use_rs2_f   = 1'($urandom);
      if ($urandom_range(0, 99) < 6) hr = ~hr;
      halt_req    = hr;
      resume      = ($urandom_range(0, 99) < 20);
      cycle();
    end
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
